eeprom_seq: RTL and testbench

- Command sequencer that sits directly upstream of the iic_com byte engine and drives its Start_Sig/Addr_Sig/WrData interface.
- On a Go pulse it writes a NUM_BYTES incrementing pattern to the 24C-series EEPROM, waiting the internal write-cycle time (tWR) after each byte.
- It then reads every byte back, compares each against the expected value, and reports pass/fail, error count, first failing address and last read byte for the LED/ILA observation logic.

---
 rtl/eeprom_pkg.sv | 17 +
 rtl/eeprom_twr_timer.sv | 31 +++
 rtl/eeprom_seq.sv | 178 +++++++++++++++++
 tb/tb_eeprom_seq.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM write/verify sequencer and the iic_com byte engine.
package eeprom_pkg;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_RD   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_TWR_WAIT,
    ST_RD_REQ,
    ST_CHECK,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/eeprom_twr_timer.sv
// Loadable 32-bit down-counter that parks at zero; used to space commands by the EEPROM write-cycle time.
module eeprom_twr_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  output logic        zero_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/eeprom_seq.sv
// Writes an incrementing pattern to a 24C-series EEPROM through iic_com, then reads it back and
// reports pass/fail, mismatch count, first failing address and the last byte read.
module eeprom_seq
  import eeprom_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 200_000_000,
  parameter int unsigned TWR_US      = 5,
  parameter int unsigned NUM_BYTES   = 16,
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter logic [7:0]  SEED        = 8'h12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Go,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [7:0] Err_Cnt,
  output logic [7:0] Fail_Addr,
  output logic [7:0] Last_Rd,
  output logic [1:0] Start_Sig,
  output logic [7:0] Addr_Sig,
  output logic [7:0] WrData,
  input  logic [7:0] RdData,
  input  logic       Done_Sig
);

  localparam int unsigned TWR_CYC  = CLK_FREQ_HZ / 1_000_000 * TWR_US;
  localparam logic [31:0] TWR_LOAD = (TWR_CYC == 0) ? '0 : 32'(TWR_CYC - 1);
  localparam logic [7:0]  LAST_IDX = 8'(NUM_BYTES - 1);

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [1:0] start_q, start_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wrdata_q, wrdata_d;
  logic [7:0] last_rd_q, last_rd_d;
  logic [7:0] err_q, err_d;
  logic [7:0] fail_q, fail_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       tmr_load;
  logic       tmr_zero;
  logic [7:0] exp_data;

  eeprom_twr_timer u_twr_timer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (tmr_load),
    .load_val_i (TWR_LOAD),
    .zero_o     (tmr_zero)
  );

  assign exp_data = SEED + idx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start_d   = start_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    last_rd_d = last_rd_q;
    err_d     = err_q;
    fail_d    = fail_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    tmr_load  = 1'b0;

    // Start_Sig is registered and set together with the state it belongs to,
    // so it only ever changes on a state transition.
    unique case (state_q)
      ST_IDLE: begin
        if (Go) begin
          idx_d    = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          fail_d   = 8'hFF;
          addr_d   = BASE_ADDR;
          wrdata_d = SEED;
          start_d  = CMD_WR;
          busy_d   = 1'b1;
          state_d  = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (Done_Sig) begin
          start_d  = CMD_IDLE;
          tmr_load = 1'b1;
          state_d  = ST_TWR_WAIT;
        end
      end
      ST_TWR_WAIT: begin
        if (tmr_zero) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            start_d = CMD_RD;
            state_d = ST_RD_REQ;
          end else begin
            idx_d   = idx_q + 8'd1;
            start_d = CMD_WR;
            state_d = ST_WR_REQ;
          end
          addr_d   = BASE_ADDR + idx_d;
          wrdata_d = SEED + idx_d;
        end
      end
      ST_RD_REQ: begin
        if (Done_Sig) begin
          last_rd_d = RdData;
          start_d   = CMD_IDLE;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (last_rd_q != exp_data) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (err_q == '0)    fail_d = addr_q;
        end
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 8'd1;
          addr_d  = BASE_ADDR + idx_d;
          start_d = CMD_RD;
          state_d = ST_RD_REQ;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      start_q   <= CMD_IDLE;
      addr_q    <= '0;
      wrdata_q  <= '0;
      last_rd_q <= '0;
      err_q     <= '0;
      fail_q    <= 8'hFF;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      start_q   <= start_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      last_rd_q <= last_rd_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign Start_Sig = start_q;
  assign Addr_Sig  = addr_q;
  assign WrData    = wrdata_q;
  assign Last_Rd   = last_rd_q;
  assign Err_Cnt   = err_q;
  assign Fail_Addr = fail_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Pass      = pass_q;

endmodule

// File: tb/tb_eeprom_seq.sv
// Bench for eeprom_seq: three parameterisations share one behavioural iic_com model with a 256-byte array.
module tb_eeprom_seq;
  import eeprom_pkg::*;

  logic       CLK;
  logic       RST;
  logic       go     [3];
  logic       busy   [3];
  logic       done   [3];
  logic       pass   [3];
  logic [7:0] err    [3];
  logic [7:0] fail   [3];
  logic [7:0] lastrd [3];
  logic [1:0] start  [3];
  logic [7:0] addr   [3];
  logic [7:0] wrd    [3];
  logic [7:0] RdData;
  logic       Done_Sig;

  int tests  = 0;
  int failed = 0;

  // model state
  logic [7:0] mem [256];
  int         sel = 0;
  int         done_cnt, wr_cnt, rd_cnt, min_gap;
  bit         cor_en = 0, all_zero = 0;
  logic [7:0] cor_addr = 8'h00, cor_val = 8'h00;

  // per-DUT configuration (NUM_BYTES, BASE_ADDR, SEED)
  int cfg_n    [3] = '{4, 4, 256};
  int cfg_base [3] = '{8'h00, 8'hFE, 8'h00};
  int cfg_seed [3] = '{8'h12, 8'hFE, 8'h01};

  eeprom_seq #(.CLK_FREQ_HZ(1_000_000), .TWR_US(3), .NUM_BYTES(4), .BASE_ADDR(8'h00), .SEED(8'h12)) dut_a (
    .CLK(CLK), .RST(RST), .Go(go[0]), .Busy(busy[0]), .Done(done[0]), .Pass(pass[0]),
    .Err_Cnt(err[0]), .Fail_Addr(fail[0]), .Last_Rd(lastrd[0]), .Start_Sig(start[0]),
    .Addr_Sig(addr[0]), .WrData(wrd[0]), .RdData(RdData), .Done_Sig(Done_Sig));

  eeprom_seq #(.CLK_FREQ_HZ(1_000_000), .TWR_US(3), .NUM_BYTES(4), .BASE_ADDR(8'hFE), .SEED(8'hFE)) dut_c (
    .CLK(CLK), .RST(RST), .Go(go[1]), .Busy(busy[1]), .Done(done[1]), .Pass(pass[1]),
    .Err_Cnt(err[1]), .Fail_Addr(fail[1]), .Last_Rd(lastrd[1]), .Start_Sig(start[1]),
    .Addr_Sig(addr[1]), .WrData(wrd[1]), .RdData(RdData), .Done_Sig(Done_Sig));

  eeprom_seq #(.CLK_FREQ_HZ(1_000_000), .TWR_US(3), .NUM_BYTES(256), .BASE_ADDR(8'h00), .SEED(8'h01)) dut_d (
    .CLK(CLK), .RST(RST), .Go(go[2]), .Busy(busy[2]), .Done(done[2]), .Pass(pass[2]),
    .Err_Cnt(err[2]), .Fail_Addr(fail[2]), .Last_Rd(lastrd[2]), .Start_Sig(start[2]),
    .Addr_Sig(addr[2]), .WrData(wrd[2]), .RdData(RdData), .Done_Sig(Done_Sig));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // iic_com model: Done_Sig four cycles after Start_Sig leaves idle; also measures idle gap after writes.
  initial begin
    int         pend;
    logic [1:0] prev, pcmd;
    logic [7:0] paddr, pdata;
    bit         gap_on;
    int         gap;
    pend = 0; prev = CMD_IDLE; pcmd = CMD_IDLE; paddr = '0; pdata = '0; gap_on = 0; gap = 0;
    Done_Sig = 1'b0;
    RdData   = '0;
    forever begin
      @(posedge CLK); #1;
      Done_Sig = 1'b0;
      if (done[sel] === 1'b1) done_cnt++;
      if (RST) begin
        pend = 0; prev = CMD_IDLE; gap_on = 0;
      end else begin
        if (gap_on) begin
          if (start[sel] == CMD_IDLE) gap++;
          else begin
            if (gap < min_gap) min_gap = gap;
            gap_on = 0;
          end
        end
        if (pend != 0) begin
          pend--;
          if (pend == 0) begin
            if (pcmd == CMD_WR) begin
              mem[paddr] = pdata; wr_cnt++; gap_on = 1; gap = 0;
            end else begin
              if (all_zero) RdData = 8'h00;
              else if (cor_en && paddr == cor_addr) RdData = cor_val;
              else RdData = mem[paddr];
              rd_cnt++;
            end
            Done_Sig = 1'b1;
          end
        end else if (start[sel] != CMD_IDLE && prev == CMD_IDLE) begin
          pend = 4; pcmd = start[sel]; paddr = addr[sel]; pdata = wrd[sel];
        end
        prev = start[sel];
      end
    end
  end

  // Reference: outcome of a full run from the byte-pattern rules, independent of RTL structure.
  function automatic void ref_run(input int s, output int e_err, output int e_fail, output int e_last);
    int a, e, r;
    e_err = 0; e_fail = 8'hFF; e_last = 0;
    for (int k = 0; k < cfg_n[s]; k++) begin
      a = (cfg_base[s] + k) % 256;
      e = (cfg_seed[s] + k) % 256;
      r = e;
      if (all_zero) r = 0;
      else if (cor_en && a == int'(cor_addr)) r = int'(cor_val);
      if (r != e) begin
        if (e_err == 0) e_fail = a;
        e_err++;
      end
      e_last = r;
    end
    if (e_err > 255) e_err = 255;
  endfunction

  task automatic start_seq(input int s);
    sel = s; done_cnt = 0; wr_cnt = 0; rd_cnt = 0; min_gap = 1000;
    @(negedge CLK); go[s] = 1'b1;
    @(negedge CLK); go[s] = 1'b0;
    tests++;
    if (busy[s] !== 1'b1) begin
      failed++; $display("FAIL busy_after_go dut%0d: got %b want 1", s, busy[s]);
    end
  endtask

  task automatic wait_done(input int s, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge CLK);
      if (done[s] === 1'b1) ok = 1;
    end
    if (!ok) begin
      tests++; failed++; $display("FAIL done_timeout dut%0d: no Done within %0d cycles", s, budget);
    end
  endtask

  task automatic test_reset;
    logic [52:0] got, want;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) go[i] = 1'b0;
    repeat (3) @(negedge CLK);
    want = {2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 3; i++) begin
      got = {start[i], addr[i], wrd[i], lastrd[i], err[i], fail[i], busy[i], done[i], pass[i], 8'h00};
      tests++;
      if (got !== want) begin
        failed++; $display("FAIL reset_state dut%0d: got %h want %h", i, got, want);
      end
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_write_verify;
    bit ok;
    int e_err, e_fail, e_last;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    cor_en = 0; all_zero = 0;
    repeat ($urandom_range(0, 5)) @(negedge CLK);
    start_seq(0);
    wait_done(0, 500, ok);
    ref_run(0, e_err, e_fail, e_last);
    tests++;
    if ({pass[0], err[0], fail[0], lastrd[0]} !== {1'b1, 8'(e_err), 8'(e_fail), 8'(e_last)}) begin
      failed++; $display("FAIL wv_result: got pass=%b err=%0d fail=%h last=%h want 1 %0d %h %h",
                         pass[0], err[0], fail[0], lastrd[0], e_err, e_fail, e_last);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (mem[k] !== 8'(8'h12 + k)) begin
        failed++; $display("FAIL wv_mem[%0d]: got %h want %h", k, mem[k], 8'(8'h12 + k));
      end
    end
    repeat (10) @(negedge CLK);
    tests++;
    if (min_gap < 3) begin
      failed++; $display("FAIL twr_gap: got %0d idle cycles want >=3", min_gap);
    end
    tests++;
    if ({done_cnt, wr_cnt, rd_cnt} !== {32'd1, 32'd4, 32'd4}) begin
      failed++; $display("FAIL wv_counts: got done=%0d wr=%0d rd=%0d want 1 4 4", done_cnt, wr_cnt, rd_cnt);
    end
    tests++;
    if (busy[0] !== 1'b0 || pass[0] !== 1'b1) begin
      failed++; $display("FAIL wv_after: got busy=%b pass=%b want 0 1", busy[0], pass[0]);
    end
  endtask

  task automatic test_corrupt;
    bit ok;
    int e_err, e_fail, e_last;
    cor_en = 1; cor_addr = 8'h02; cor_val = 8'h00; all_zero = 0;
    start_seq(0);
    wait_done(0, 500, ok);
    ref_run(0, e_err, e_fail, e_last);
    tests++;
    if ({pass[0], err[0], fail[0]} !== {1'b0, 8'd1, 8'h02} || e_err != 1 || e_fail != 2) begin
      failed++; $display("FAIL corrupt_addr2: got pass=%b err=%0d fail=%h want 0 1 02", pass[0], err[0], fail[0]);
    end
    repeat (20) @(negedge CLK);
    tests++;
    if ({pass[0], err[0], fail[0]} !== {1'b0, 8'd1, 8'h02}) begin
      failed++; $display("FAIL corrupt_hold: got pass=%b err=%0d fail=%h want 0 1 02", pass[0], err[0], fail[0]);
    end
    cor_en = 0;
  endtask

  task automatic test_random_corrupt;
    bit ok;
    int e_err, e_fail, e_last;
    for (int it = 0; it < 5; it++) begin
      cor_en = 1; cor_addr = 8'($urandom_range(0, 5)); cor_val = 8'($urandom);
      if (it == 0) cor_val = 8'h12 + cor_addr;
      start_seq(0);
      wait_done(0, 500, ok);
      ref_run(0, e_err, e_fail, e_last);
      tests++;
      if ({pass[0], err[0], fail[0], lastrd[0]} !== {e_err == 0, 8'(e_err), 8'(e_fail), 8'(e_last)}) begin
        failed++; $display("FAIL rand_corrupt it%0d a=%h v=%h: got pass=%b err=%0d fail=%h last=%h want %b %0d %h %h",
                           it, cor_addr, cor_val, pass[0], err[0], fail[0], lastrd[0], e_err == 0, e_err, e_fail, e_last);
      end
    end
    cor_en = 0;
  endtask

  task automatic test_wrap;
    bit ok;
    int e_err, e_fail, e_last;
    logic [7:0] a;
    cor_en = 0; all_zero = 0;
    start_seq(1);
    wait_done(1, 500, ok);
    ref_run(1, e_err, e_fail, e_last);
    tests++;
    if ({pass[1], err[1], fail[1], lastrd[1]} !== {1'b1, 8'(e_err), 8'(e_fail), 8'(e_last)}) begin
      failed++; $display("FAIL wrap_result: got pass=%b err=%0d fail=%h last=%h want 1 %0d %h %h",
                         pass[1], err[1], fail[1], lastrd[1], e_err, e_fail, e_last);
    end
    for (int k = 0; k < 4; k++) begin
      a = 8'(8'hFE + k);
      tests++;
      if (mem[a] !== a) begin
        failed++; $display("FAIL wrap_mem[%h]: got %h want %h", a, mem[a], a);
      end
    end
  endtask

  task automatic test_saturate;
    bit ok;
    int e_err, e_fail, e_last;
    cor_en = 0; all_zero = 1;
    start_seq(2);
    wait_done(2, 12000, ok);
    ref_run(2, e_err, e_fail, e_last);
    tests++;
    if ({pass[2], err[2], fail[2], lastrd[2]} !== {1'b0, 8'(e_err), 8'(e_fail), 8'(e_last)} || e_err != 255) begin
      failed++; $display("FAIL saturate: got pass=%b err=%0d fail=%h last=%h want 0 255 %h %h",
                         pass[2], err[2], fail[2], lastrd[2], e_fail, e_last);
    end
    all_zero = 0;
  endtask

  task automatic test_go_ignored;
    bit ok, seen;
    int e_err, e_fail, e_last;
    cor_en = 0; all_zero = 0;
    start_seq(0);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge CLK);
      if (start[0] == CMD_WR) seen = 1;
    end
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge CLK);
      if (start[0] == CMD_IDLE) seen = 1;
    end
    tests++;
    if (!seen) begin
      failed++; $display("FAIL go_ignored_reach_twr: Start_Sig never returned to 00");
    end
    go[0] = 1'b1;
    @(negedge CLK); go[0] = 1'b0;
    wait_done(0, 500, ok);
    ref_run(0, e_err, e_fail, e_last);
    repeat (20) @(negedge CLK);
    tests++;
    if ({done_cnt, wr_cnt, rd_cnt} !== {32'd1, 32'd4, 32'd4}) begin
      failed++; $display("FAIL go_ignored_counts: got done=%0d wr=%0d rd=%0d want 1 4 4", done_cnt, wr_cnt, rd_cnt);
    end
    tests++;
    if ({pass[0], err[0], fail[0], lastrd[0], busy[0]} !== {1'b1, 8'(e_err), 8'(e_fail), 8'(e_last), 1'b0}) begin
      failed++; $display("FAIL go_ignored_result: got pass=%b err=%0d fail=%h last=%h busy=%b want 1 %0d %h %h 0",
                         pass[0], err[0], fail[0], lastrd[0], busy[0], e_err, e_fail, e_last);
    end
  endtask

  task automatic test_reset_midflight;
    bit ok, seen;
    start_seq(0);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge CLK);
      if (start[0] == CMD_WR && wr_cnt == 2) seen = 1;
    end
    #2 RST = 1'b1;
    #1;
    tests++;
    if ({seen, start[0], busy[0], fail[0]} !== {1'b1, 2'b00, 1'b0, 8'hFF}) begin
      failed++; $display("FAIL rst_midflight: got seen=%b start=%b busy=%b fail=%h want 1 00 0 ff",
                         seen, start[0], busy[0], fail[0]);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    start_seq(0);
    wait_done(0, 500, ok);
    tests++;
    if ({pass[0], err[0], fail[0], lastrd[0]} !== {1'b1, 8'd0, 8'hFF, 8'h15}) begin
      failed++; $display("FAIL rst_recover: got pass=%b err=%0d fail=%h last=%h want 1 0 ff 15",
                         pass[0], err[0], fail[0], lastrd[0]);
    end
  endtask

  initial begin
    test_reset;
    test_write_verify;
    test_corrupt;
    test_random_corrupt;
    test_wrap;
    test_saturate;
    test_go_ignored;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
